ds_addr_gen: RTL

//  Down-sampling address sequencer. Drives the read row/col (RRR/CRR) and write
//  row/col (RWR/CWR) byte buses into the memory address register stage.
//  For each output pixel it walks the FxF input window (F = 2**SCALE_LOG2),

---
 rtl/ds_pkg.sv | 25 ++
 rtl/ds_wrap_counter.sv | 29 ++
 rtl/ds_addr_gen.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ds_pkg.sv
// Shared definitions for the down-sampling address sequencer and its control unit.
package ds_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ds_state_t;

    localparam logic [1:0] MAR_HOLD = 2'b00;
    localparam logic [1:0] MAR_AC   = 2'b01;
    localparam logic [1:0] MAR_RD   = 2'b10;
    localparam logic [1:0] MAR_WR   = 2'b11;

    // MAR select the control unit should use while the sequencer sits in a given state.
    function automatic logic [1:0] mar_sel(input ds_state_t st);
        case (st)
            READ:    return MAR_RD;
            WRITE:   return MAR_WR;
            default: return MAR_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/ds_wrap_counter.sv
// Up-counter that wraps from MAX back to 0; at_max lets instances be chained.
module ds_wrap_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    assign at_max = (value == MAX_V);

    // Clear wins over increment; increment wraps at MAX.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= at_max ? '0 : value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ds_addr_gen.sv
// Down-sampling address sequencer: walks each FxF read window, then issues one write.
//
//  state | meaning
//  IDLE  | waiting for start after reset
//  READ  | presenting window read address (dy,dx); step advances within the window
//  WRITE | presenting output pixel address; step moves to the next output pixel
//  DONE  | frame complete, counters hold last write position until start
import ds_pkg::*;

module ds_addr_gen #(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int SCALE_LOG2 = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        step,
    output logic [7:0]  RRR_out,
    output logic [7:0]  CRR_out,
    output logic [7:0]  RWR_out,
    output logic [7:0]  CWR_out,
    output logic        rd_phase,
    output logic        wr_phase,
    output logic        win_first,
    output logic        win_last,
    output logic        done,
    output logic [15:0] wr_count
);

    localparam int F     = 1 << SCALE_LOG2;
    localparam int OUT_W = IMG_W >> SCALE_LOG2;
    localparam int OUT_H = IMG_H >> SCALE_LOG2;

    ds_state_t  state, state_nxt;
    logic       clr, dx_inc, dy_inc, col_inc, row_inc, wr_inc;
    logic [7:0] dx_val, dy_val, col_val, row_val;
    logic       dx_max, dy_max, col_max, row_max;

    assign dy_inc  = dx_inc && dx_max;
    assign row_inc = col_inc && col_max;

    ds_wrap_counter #(.WIDTH(8), .MAX(F - 1)) u_dx (
        .clock(clock), .resetn(resetn), .clr(clr), .inc(dx_inc),
        .value(dx_val), .at_max(dx_max)
    );

    ds_wrap_counter #(.WIDTH(8), .MAX(F - 1)) u_dy (
        .clock(clock), .resetn(resetn), .clr(clr), .inc(dy_inc),
        .value(dy_val), .at_max(dy_max)
    );

    ds_wrap_counter #(.WIDTH(8), .MAX(OUT_W - 1)) u_col (
        .clock(clock), .resetn(resetn), .clr(clr), .inc(col_inc),
        .value(col_val), .at_max(col_max)
    );

    ds_wrap_counter #(.WIDTH(8), .MAX(OUT_H - 1)) u_row (
        .clock(clock), .resetn(resetn), .clr(clr), .inc(row_inc),
        .value(row_val), .at_max(row_max)
    );

    // Buses follow the counters directly so a new address is visible the cycle it is reached.
    assign RRR_out = (row_val << SCALE_LOG2) + dy_val;
    assign CRR_out = (col_val << SCALE_LOG2) + dx_val;
    assign RWR_out = row_val;
    assign CWR_out = col_val;

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counter strobes and phase flags.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        dx_inc    = 1'b0;
        col_inc   = 1'b0;
        wr_inc    = 1'b0;
        rd_phase  = 1'b0;
        wr_phase  = 1'b0;
        win_first = 1'b0;
        win_last  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                rd_phase  = 1'b1;
                win_first = (dx_val == 8'd0) && (dy_val == 8'd0);
                win_last  = dx_max && dy_max;
                if (step) begin
                    dx_inc = 1'b1;
                    if (dx_max && dy_max) begin
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                wr_phase = 1'b1;
                if (step) begin
                    wr_inc = 1'b1;
                    // The final pixel leaves col/row parked on the last write address.
                    if (col_max && row_max) begin
                        state_nxt = DONE;
                    end else begin
                        col_inc   = 1'b1;
                        state_nxt = READ;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = READ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output pixels written this frame; restarts from zero with each new frame.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_count <= 16'd0;
        end else if (clr) begin
            wr_count <= 16'd0;
        end else if (wr_inc) begin
            wr_count <= wr_count + 16'd1;
        end
    end

endmodule
